// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings plus the default datapath width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bit 1 of the opcode selects divide, bit 0 selects signed operation.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Combinational sign handling around the unsigned iterative core: magnitudes
// and sign flags of the operands going in, two's-complement fix-up coming out.
module muldiv_sign_adjust
    import muldiv_pkg::*;
#(
    parameter int size = MULDIV_WIDTH
) (
    input  logic              signed_i,
    input  logic [size-1:0]   src1_i,
    input  logic [size-1:0]   src2_i,
    output logic [size-1:0]   abs1_o,
    output logic [size-1:0]   abs2_o,
    output logic              sign1_o,
    output logic              sign2_o,
    input  logic [2*size-1:0] prod_mag_i,
    input  logic              neg_prod_i,
    output logic [2*size-1:0] prod_o,
    input  logic [size-1:0]   quot_mag_i,
    input  logic              neg_quot_i,
    output logic [size-1:0]   quot_o,
    input  logic [size-1:0]   rem_mag_i,
    input  logic              neg_rem_i,
    output logic [size-1:0]   rem_o
);

    // The most negative value maps to itself, which reads correctly as an
    // unsigned magnitude.
    assign sign1_o = signed_i & src1_i[size-1];
    assign sign2_o = signed_i & src2_i[size-1];
    assign abs1_o  = sign1_o ? (~src1_i + 1'b1) : src1_i;
    assign abs2_o  = sign2_o ? (~src2_i + 1'b1) : src2_i;

    assign prod_o  = neg_prod_i ? (~prod_mag_i + 1'b1) : prod_mag_i;
    assign quot_o  = neg_quot_i ? (~quot_mag_i + 1'b1) : quot_mag_i;
    assign rem_o   = neg_rem_i  ? (~rem_mag_i + 1'b1)  : rem_mag_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide,
// one bit per clock. Optional abort input enabled by macro MULDIV_FLUSH_EN.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int size = MULDIV_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [size-1:0] src1_i,
    input  logic [size-1:0] src2_i,
`ifdef MULDIV_FLUSH_EN
    input  logic            flush_i,
`endif
    output logic            busy_o,
    output logic            done_o,
    output logic [size-1:0] hi_o,
    output logic [size-1:0] lo_o,
    output logic            div_by_zero_o
);

    localparam int CNT_W = (size > 1) ? $clog2(size) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [size-1:0]   acc_hi_q, acc_hi_d;
    logic [size-1:0]   acc_lo_q, acc_lo_d;
    logic [size-1:0]   opnd_q, opnd_d;
    logic [size-1:0]   src1_raw_q, src1_raw_d;
    logic              is_div_q, is_div_d;
    logic              dz_q, dz_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [size-1:0]   hi_q, hi_d;
    logic [size-1:0]   lo_q, lo_d;
    logic              dz_out_q, dz_out_d;

    logic              flush_w;
    logic              accept;
    logic              last_iter;
    logic              finish;

    logic [size-1:0]   abs1, abs2;
    logic              sign1, sign2;
    logic [2*size-1:0] prod_adj;
    logic [size-1:0]   quot_adj, rem_adj;

    logic [size:0]     mul_sum;
    logic [size:0]     div_shift;
    logic              div_ge;
    logic [size-1:0]   div_sub;
    logic [size-1:0]   hi_nx, lo_nx;

`ifdef MULDIV_FLUSH_EN
    assign flush_w = flush_i;
`else
    assign flush_w = 1'b0;
`endif

    assign accept    = (state_q == ST_IDLE) && start_i;
    assign last_iter = (state_q == ST_CALC) && (cnt_q == CNT_W'(size - 1));
    assign finish    = last_iter && !flush_w;

    muldiv_sign_adjust #(.size(size)) u_sign_adjust (
        .signed_i   (op_is_signed(op_i)),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .abs1_o     (abs1),
        .abs2_o     (abs2),
        .sign1_o    (sign1),
        .sign2_o    (sign2),
        .prod_mag_i ({hi_nx, lo_nx}),
        .neg_prod_i (neg_res_q),
        .prod_o     (prod_adj),
        .quot_mag_i (lo_nx),
        .neg_quot_i (neg_res_q),
        .quot_o     (quot_adj),
        .rem_mag_i  (hi_nx),
        .neg_rem_i  (neg_rem_q),
        .rem_o      (rem_adj)
    );

    // One iteration. Multiply keeps {partial, multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(size+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[size-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    // The difference is below 2**size whenever it is kept, so low bits suffice.
    assign div_sub   = div_shift[size-1:0] - opnd_q;

    always_comb begin
        if (is_div_q) begin
            hi_nx = div_ge ? div_sub : div_shift[size-1:0];
            lo_nx = {acc_lo_q[size-2:0], div_ge};
        end else begin
            hi_nx = mul_sum[size:1];
            lo_nx = {mul_sum[0], acc_lo_q[size-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_CALC;
            ST_CALC: begin
                if (flush_w)        state_d = ST_IDLE;
                else if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != ST_IDLE);
        done_o = (state_q == ST_DONE);
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        src1_raw_d = src1_raw_q;
        is_div_d   = is_div_q;
        dz_d       = dz_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dz_out_d   = dz_out_q;

        if (accept) begin
            cnt_d      = '0;
            is_div_d   = op_is_div(op_i);
            dz_d       = op_is_div(op_i) && (src2_i == '0);
            neg_res_d  = sign1 ^ sign2;
            neg_rem_d  = sign1;
            src1_raw_d = src1_i;
            acc_hi_d   = '0;
            if (op_is_div(op_i)) begin
                acc_lo_d = abs1;
                opnd_d   = abs2;
            end else begin
                acc_lo_d = abs2;
                opnd_d   = abs1;
            end
        end else if (state_q == ST_CALC) begin
            cnt_d    = cnt_q + CNT_W'(1);
            acc_hi_d = hi_nx;
            acc_lo_d = lo_nx;
            if (finish) begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_adj;
                    dz_out_d     = 1'b0;
                end else if (dz_q) begin
                    hi_d     = src1_raw_q;
                    lo_d     = '1;
                    dz_out_d = 1'b1;
                end else begin
                    hi_d     = rem_adj;
                    lo_d     = quot_adj;
                    dz_out_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            src1_raw_q <= '0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dz_out_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            src1_raw_q <= src1_raw_d;
            is_div_q   <= is_div_d;
            dz_q       <= dz_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dz_out_q   <= dz_out_d;
        end
    end

    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dz_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed and random operations checked
// against an arithmetic reference model; honours MULDIV_FLUSH_EN if defined.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t exp_q[$];
    res_t prev;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .op_i         (op),
        .src1_i       (src1),
        .src2_i       (src2),
`ifdef MULDIV_FLUSH_EN
        .flush_i      (flush),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo),
        .div_by_zero_o(dz)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference result straight from the arithmetic definitions.
    function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint sa, sb, p;
        logic [63:0] up;
        int ia, ib;
        r = '0;
        case (o)
            2'b00: begin
                up = 64'(a) * 64'(b);
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            2'b01: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = sa * sb;
                up = p;
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    r.dz = 1'b1;
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                end else if (o == 2'b10) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000;
                    r.hi = 32'd0;
                end else begin
                    ia = a;
                    ib = b;
                    r.lo = ia / ib;
                    r.hi = ia % ib;
                end
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("dz", 64'(dz), 64'(e.dz));
                $display("result hi=%h lo=%h dz=%0d (expect hi=%h lo=%h dz=%0d)",
                         hi, lo, dz, e.hi, e.lo, e.dz);
            end
        end
    end

    // Issue one operation and follow it to DONE; optional mid-CALC disturbances.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input int abort_at, input int flush_at);
        res_t e;
        int k;
        int busy_cnt;
        @(negedge clk);
        chk("idle_before_start", 64'(busy), 64'd0);
        e = model(o, a, b);
        start = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        exp_q.push_back(e);
        $display("issue op=%0d a=%h b=%h", o, a, b);
        @(posedge clk);
        k = 0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) break;
            if (inject && k == 3) begin
                start = 1'b1;
                op = 2'($urandom_range(0, 3));
                src1 = $urandom;
                src2 = $urandom;
            end
            if (k == 5) begin
                chk("hold_hi", 64'(hi), 64'(prev.hi));
                chk("hold_lo", 64'(lo), 64'(prev.lo));
                chk("hold_dz", 64'(dz), 64'(prev.dz));
            end
            if (abort_at != 0 && k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_done", 64'(done), 64'd0);
                chk("abort_hi", 64'(hi), 64'd0);
                chk("abort_lo", 64'(lo), 64'd0);
                chk("abort_dz", 64'(dz), 64'd0);
                exp_q.delete();
                prev = '0;
                repeat (40) @(negedge clk);
                return;
            end
`ifdef MULDIV_FLUSH_EN
            if (flush_at != 0 && k == flush_at) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                chk("flush_busy", 64'(busy), 64'd0);
                chk("flush_hi", 64'(hi), 64'(prev.hi));
                chk("flush_lo", 64'(lo), 64'(prev.lo));
                exp_q.delete();
                repeat (40) @(negedge clk);
                return;
            end
`endif
            k++;
            if (k > 60) begin
                total++;
                bad++;
                $display("FAIL timeout: got no done after %0d cycles expected done at 32", k);
                exp_q.delete();
                return;
            end
        end
        chk("latency", 64'(k), 64'd32);
        chk("busy_cycles", 64'(busy_cnt), 64'd33);
        prev = e;
    endtask

    initial begin
        prev = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);

        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0);
        run_op(2'b10, 32'd100, 32'd7, 1'b1, 0, 0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
        run_op(2'b10, 32'h0000_1234, 32'd0, 1'b0, 0, 0);
        run_op(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 0, 0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0, 0, 0);
`ifdef MULDIV_FLUSH_EN
        run_op(2'b00, 32'h1111_2222, 32'h3333_4444, 1'b0, 0, 5);
`endif
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 10, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int sel;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = 32'($urandom_range(1, 20));
            else if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 3) rb = -32'($urandom_range(1, 20));
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 0, 0);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
